mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//   Memory-side responder for the control unit's en/ren/wen/addr/din/dout port.
//   Holds a word-addressed RAM and serves one request at a time.
//   Reads return data after a fixed latency with an ack pulse; writes complete in one cycle.
//   Lets the FSM wait on ack/busy instead of counting hard-coded wait states.
// PARAMETERS
//   ADDR_W  16  width of addr port (word address)
//   DATA_W  32  width of din/dout
//   MEM_AW  13  implemented index bits; DEPTH = 2**MEM_AW words (8192)
//   RD_LAT  3   read latency in cycles, legal range 1..7
// PORTS
//   clk      in   1       system clock, all logic on rising edge
//   reset_n  in   1       asynchronous, active-low reset
//   en       in   1       request strobe
//   ren      in   1       read request (qualified by en)
//   wen      in   1       write request (qualified by en)
//   addr     in   ADDR_W  word address
//   din      in   DATA_W  write data
//   dout     out  DATA_W  read data, holds last read result
//   ack      out  1       one-cycle completion pulse (read or write)
//   busy     out  1       read in flight; new requests ignored
//   err      out  1       out-of-range pulse (only with MEM_OOR_CHECK_EN)
// BEHAVIOUR
//   - Reset (async on reset_n=0):
//     - dout=0, ack=0, busy=0, err=0, FSM=IDLE, latency counter=0.
//     - RAM contents are not cleared.
//   - Accept condition: en & ~busy & (ren ^ wen), sampled at a rising edge.
//     - en with ren=wen=1: illegal; ignored, no ack, no RAM change.
//     - en with ren=wen=0: ignored.
//   - FSM states: IDLE, READ.
//     - Write is handled in IDLE.
//   - Write accepted at edge k:
//     - mem[idx] <= din at edge k.
//     - ack=1 during cycle k..k+1 only.
//     - busy stays 0; dout unchanged.
//   - Read accepted at edge k:
//     - Latch idx; go READ; busy=1; counter=RD_LAT-1.
//     - At edge k+RD_LAT: dout <= mem[idx], ack=1, busy=0, FSM returns to IDLE.
//     - RD_LAT=1: busy never visible high; dout/ack update at edge k+1.
//   - Back-to-back: a new request is accepted in the cycle where ack=1 (busy=0 there).
//   - Requests while busy=1 are dropped, not queued.
//     - en/addr may change or drop during READ; the latched request still completes.
//   - Read-after-write to the same address in consecutive requests returns the new data.
//   - idx = addr[MEM_AW-1:0]; counter width 3 bits.
//   - Reset mid-read: the read is abandoned, no ack, outputs go to reset values.
// CONFIGURATION
//   MEM_OOR_CHECK_EN defined:
//     - Out of range when addr[ADDR_W-1:MEM_AW] != 0.
//     - OOR write: dropped, RAM unchanged; ack and err pulse together.
//     - OOR read: full RD_LAT latency; dout <= 0; ack and err pulse together.
//   MEM_OOR_CHECK_EN undefined:
//     - Upper address bits ignored; address wraps modulo DEPTH.
//     - err tied to 0.
// TESTING
//   1. Reset: reset_n=0 mid-run -> dout=0, ack=0, busy=0 immediately, without waiting for a clock edge.
//   2. Write then read (RD_LAT=3):
//      - Stimulus: write 0xDEADBEEF @ addr 0x0010; read 0x0010 next cycle.
//      - Response: ack 1 cycle after write; busy high 3 cycles; dout=0xDEADBEEF with ack 3 cycles after read accept.
//   3. Busy drop: during read of 0x0010, issue write 0x12345678 @ 0x0010.
//      -> no ack for it; later read of 0x0010 returns 0xDEADBEEF.
//   4. Illegal request: en=1, ren=wen=1 @ 0x0020 -> no ack; mem[0x20] unchanged.
//   5. Wrap vs. OOR: write 0xCAFEF00D @ addr 0x2005.
//      - Macro off: read 0x0005 returns 0xCAFEF00D.
//      - Macro on: err pulses with ack; read 0x0005 returns its prior value.
//   6. Abort: assert reset_n=0 one cycle after a read accept -> no ack after reset release; next read completes normally.

Source files
------------

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-addressed RAM responder with fixed read latency and ack/busy handshake
//
// Serves one request at a time from a control unit's en/ren/wen/addr/din/dout port.
// Writes complete at the accepting edge with a one-cycle ack. Reads return data
// RD_LAT cycles after acceptance with a one-cycle ack. busy is high while a read is in flight.
// Requests that arrive while busy is high are dropped.
//
// Optional feature macro: MEM_OOR_CHECK_EN
//   defined   : addresses with nonzero bits above MEM_AW are out of range. An OOR write is
//               dropped. An OOR read returns 0. In both cases err pulses together with ack.
//   undefined : upper address bits are ignored (the address wraps modulo DEPTH), and err stays 0.
//
// Ports
//   clk      in   1       system clock (rising edge)
//   reset_n  in   1       asynchronous active-low reset
//   en       in   1       request strobe
//   ren      in   1       read request (qualified by en)
//   wen      in   1       write request (qualified by en)
//   addr     in   ADDR_W  word address
//   din      in   DATA_W  write data
//   dout     out  DATA_W  read data, holds the last read result
//   ack      out  1       one-cycle completion pulse
//   busy     out  1       read in flight
//   err      out  1       out-of-range pulse (MEM_OOR_CHECK_EN only)

module mem_responder #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int MEM_AW = 13,
  parameter int RD_LAT = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              ren,
  input  logic              wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              ack,
  output logic              busy,
  output logic              err
);

  localparam int         DEPTH          = 2 ** MEM_AW;
  localparam logic [2:0] LAT_M1         = 3'(RD_LAT - 1);
  // With a single-cycle latency the read completes before busy could ever be seen.
  localparam logic       BUSY_ON_ACCEPT = (RD_LAT > 1);

  typedef enum logic {
    S_IDLE,
    S_READ
  } state_t;

  state_t              state_q;
  logic [2:0]          cnt_q;
  logic [MEM_AW-1:0]   idx_q;
  logic                oor_q;
  logic [DATA_W-1:0]   dout_q;
  logic                ack_q;
  logic                busy_q;
  logic                err_q;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                req_ok_d;
  logic                rd_accept_d;
  logic                wr_accept_d;
  logic                rd_done_d;
  logic                oor_d;
  logic [MEM_AW-1:0]   idx_d;

  assign idx_d = addr[MEM_AW-1:0];

`ifdef MEM_OOR_CHECK_EN
  assign oor_d = |addr[ADDR_W-1:MEM_AW];
`else
  logic unused_upper_addr;
  assign oor_d             = 1'b0;
  assign unused_upper_addr = ^addr[ADDR_W-1:MEM_AW];
`endif

  // Illegal (ren & wen) and empty (neither) strobes both fail the xor and are ignored.
  assign req_ok_d    = en & ~busy_q & (ren ^ wen);
  assign rd_accept_d = req_ok_d & ren;
  assign wr_accept_d = req_ok_d & wen;
  assign rd_done_d   = (state_q == S_READ) && (cnt_q == 3'd0);

  // The RAM has no reset, so its contents survive reset_n.
  always_ff @(posedge clk) begin
    if (wr_accept_d && !oor_d) begin
      mem_q[idx_d] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      dout_q  <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // With RD_LAT=1, a completing read and a fresh request can share one edge.
      // Each pulse is therefore an OR of both sources.
      ack_q <= rd_done_d | wr_accept_d;
      err_q <= (rd_done_d & oor_q) | (wr_accept_d & oor_d);

      if ((state_q == S_READ) && (cnt_q != 3'd0)) begin
        cnt_q <= cnt_q - 3'd1;
      end

      if (rd_done_d) begin
        dout_q  <= oor_q ? '0 : mem_q[idx_q];
        busy_q  <= 1'b0;
        state_q <= S_IDLE;
      end

      if (rd_accept_d) begin
        state_q <= S_READ;
        idx_q   <= idx_d;
        oor_q   <= oor_d;
        cnt_q   <= LAT_M1;
        busy_q  <= BUSY_ON_ACCEPT;
      end
    end
  end

  assign dout = dout_q;
  assign ack  = ack_q;
  assign busy = busy_q;
`ifdef MEM_OOR_CHECK_EN
  assign err  = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder (RD_LAT=3)

module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        en = 1'b0;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic [15:0] addr = '0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        ack;
  logic        busy;
  logic        err;

  int total = 0;
  int bad = 0;

  mem_responder #(.ADDR_W(16), .DATA_W(32), .MEM_AW(13), .RD_LAT(3)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .ren(ren), .wen(wen),
    .addr(addr), .din(din), .dout(dout), .ack(ack), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Present one request at a negedge, then return 1ns after the edge that samples it.
  task automatic issue(input logic r, input logic w, input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    en = 1'b1; ren = r; wen = w; addr = a; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic release_bus();
    @(negedge clk);
    en = 1'b0; ren = 1'b0; wen = 1'b0;
  endtask

  // Counts rising edges until ack is seen. The count is capped at 10, so a result of 11 means timeout.
  task automatic wait_ack(output int cycles);
    cycles = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (ack === 1'b1) return;
    end
    cycles = 11;
  endtask

  task automatic test_reset();
    #3 reset_n = 1'b0;
    #1;
    total++; if (dout !== 32'h0) begin bad++; $display("FAIL reset_dout got=%h exp=%h", dout, 32'h0); end
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", ack); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_write_read();
    int cyc;
    issue(1'b0, 1'b1, 16'h0010, 32'hDEADBEEF);
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL wr_ack got=%b exp=1", ack); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy got=%b exp=0", busy); end
    total++; if (dout !== 32'h0) begin bad++; $display("FAIL wr_dout_unchanged got=%h exp=%h", dout, 32'h0); end
    issue(1'b1, 1'b0, 16'h0010, 32'h0);
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL rd_accept_ack got=%b exp=0", ack); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rd_busy got=%b exp=1", busy); end
    release_bus();
    wait_ack(cyc);
    total++; if (cyc !== 3) begin bad++; $display("FAIL rd_latency got=%0d exp=3", cyc); end
    total++; if (dout !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%h exp=%h", dout, 32'hDEADBEEF); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rd_done_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL rd_ack_width got=%b exp=0", ack); end
  endtask

  task automatic test_busy_drop();
    int cyc;
    issue(1'b1, 1'b0, 16'h0010, 32'h0);
    issue(1'b0, 1'b1, 16'h0010, 32'h12345678);
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL drop_no_ack got=%b exp=0", ack); end
    release_bus();
    wait_ack(cyc);
    total++; if (cyc !== 2) begin bad++; $display("FAIL drop_rd_latency got=%0d exp=2", cyc); end
    total++; if (dout !== 32'hDEADBEEF) begin bad++; $display("FAIL drop_rd1 got=%h exp=%h", dout, 32'hDEADBEEF); end
    issue(1'b1, 1'b0, 16'h0010, 32'h0);
    release_bus();
    wait_ack(cyc);
    total++; if (dout !== 32'hDEADBEEF) begin bad++; $display("FAIL drop_rd2 got=%h exp=%h", dout, 32'hDEADBEEF); end
  endtask

  task automatic test_illegal();
    int cyc;
    issue(1'b0, 1'b1, 16'h0020, 32'h11111111);
    release_bus();
    issue(1'b1, 1'b1, 16'h0020, 32'h99999999);
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL illegal_ack got=%b exp=0", ack); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL illegal_busy got=%b exp=0", busy); end
    release_bus();
    issue(1'b1, 1'b0, 16'h0020, 32'h0);
    release_bus();
    wait_ack(cyc);
    total++; if (dout !== 32'h11111111) begin bad++; $display("FAIL illegal_mem got=%h exp=%h", dout, 32'h11111111); end
  endtask

  task automatic test_wrap_oor();
    int cyc;
    issue(1'b0, 1'b1, 16'h0005, 32'h55AA55AA);
    release_bus();
    issue(1'b0, 1'b1, 16'h2005, 32'hCAFEF00D);
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL hi_wr_ack got=%b exp=1", ack); end
`ifdef MEM_OOR_CHECK_EN
    total++; if (err !== 1'b1) begin bad++; $display("FAIL oor_wr_err got=%b exp=1", err); end
`else
    total++; if (err !== 1'b0) begin bad++; $display("FAIL wrap_wr_err got=%b exp=0", err); end
`endif
    release_bus();
    issue(1'b1, 1'b0, 16'h0005, 32'h0);
    release_bus();
    wait_ack(cyc);
`ifdef MEM_OOR_CHECK_EN
    total++; if (dout !== 32'h55AA55AA) begin bad++; $display("FAIL oor_rd got=%h exp=%h", dout, 32'h55AA55AA); end
    issue(1'b1, 1'b0, 16'h2005, 32'h0);
    release_bus();
    wait_ack(cyc);
    total++; if (dout !== 32'h0) begin bad++; $display("FAIL oor_rd_zero got=%h exp=%h", dout, 32'h0); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL oor_rd_err got=%b exp=1", err); end
`else
    total++; if (dout !== 32'hCAFEF00D) begin bad++; $display("FAIL wrap_rd got=%h exp=%h", dout, 32'hCAFEF00D); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL wrap_rd_err got=%b exp=0", err); end
`endif
  endtask

  task automatic test_abort();
    int cyc;
    int stray;
    issue(1'b1, 1'b0, 16'h0020, 32'h0);
    release_bus();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    total++; if (dout !== 32'h0) begin bad++; $display("FAIL abort_dout got=%h exp=%h", dout, 32'h0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL abort_ack got=%b exp=0", ack); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack !== 1'b0) stray++;
    end
    total++; if (stray !== 0) begin bad++; $display("FAIL abort_stray_ack got=%0d exp=0", stray); end
    issue(1'b1, 1'b0, 16'h0010, 32'h0);
    release_bus();
    wait_ack(cyc);
    total++; if (cyc !== 3) begin bad++; $display("FAIL abort_next_latency got=%0d exp=3", cyc); end
    total++; if (dout !== 32'hDEADBEEF) begin bad++; $display("FAIL abort_next_data got=%h exp=%h", dout, 32'hDEADBEEF); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_busy_drop();
    test_illegal();
    test_wrap_oor();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
